// File: rtl/fpu_zhinx_issue.sv
// Zhinx half-precision FPU issue stage: one request in flight, IDLE/BUSY/RESP.
// Optional watchdog abort on a stuck FPU when FPU_ZHINX_ISSUE_TIMEOUT_EN is defined.
package fpu_zhinx_pkg;
  parameter int WORD_W = 32;
  typedef enum logic [2:0] {
    FPU_HALF_ADD  = 3'd0,
    FPU_HALF_SUB  = 3'd1,
    FPU_HALF_MUL  = 3'd2,
    FPU_HALF_DIV  = 3'd3,
    FPU_HALF_SQRT = 3'd4,
    FPU_HALF_MIN  = 3'd5,
    FPU_HALF_MAX  = 3'd6,
    FPU_HALF_CMP  = 3'd7
  } fpu_operation_t;
endpackage

module fpu_zhinx_issue #(
  parameter int WORD_W = fpu_zhinx_pkg::WORD_W,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  fpu_zhinx_pkg::fpu_operation_t  req_op,
  input  logic [WORD_W-1:0]              req_a,
  input  logic [WORD_W-1:0]              req_b,
  input  logic [4:0]                     req_rd,
  output logic                           fpu_start,
  output fpu_zhinx_pkg::fpu_operation_t  fpu_operation,
  output logic [WORD_W-1:0]              fpu_a,
  output logic [WORD_W-1:0]              fpu_b,
  input  logic                           fpu_done,
  input  logic [WORD_W-1:0]              fpu_out,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [WORD_W-1:0]              rsp_data,
  output logic [4:0]                     rsp_rd,
  output logic                           rsp_err
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t state;
  state_t state_nx;

  fpu_zhinx_pkg::fpu_operation_t op_q;
  logic [WORD_W-1:0] a_q;
  logic [WORD_W-1:0] b_q;
  logic [WORD_W-1:0] data_q;
  logic [4:0]        rd_q;
  logic              err_q;
  logic              supported;
  logic              timeout;

  assign supported = req_op inside {
    fpu_zhinx_pkg::FPU_HALF_ADD,
    fpu_zhinx_pkg::FPU_HALF_SUB,
    fpu_zhinx_pkg::FPU_HALF_MUL
  };

`ifdef FPU_ZHINX_ISSUE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] cnt;

  // Held at zero outside BUSY, so every BUSY entry starts from zero.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
    end else if (state != BUSY) begin
      cnt <= '0;
    end else if (!fpu_done) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign timeout = (state == BUSY) && !fpu_done &&
                   (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          state_nx = supported ? BUSY : RESP;
        end
      end
      BUSY: begin
        if (fpu_done || timeout) begin
          state_nx = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      op_q   <= fpu_zhinx_pkg::FPU_HALF_ADD;
      a_q    <= '0;
      b_q    <= '0;
      rd_q   <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else if (state == IDLE && req_valid) begin
      op_q   <= req_op;
      a_q    <= req_a;
      b_q    <= req_b;
      rd_q   <= req_rd;
      data_q <= '0;
      err_q  <= !supported;
    end else if (state == BUSY && fpu_done) begin
      data_q <= fpu_out;
      err_q  <= 1'b0;
    end else if (timeout) begin
      data_q <= '0;
      err_q  <= 1'b1;
    end
  end

  assign req_ready     = (state == IDLE);
  assign fpu_start     = (state == BUSY);
  assign fpu_operation = op_q;
  assign fpu_a         = a_q;
  assign fpu_b         = b_q;
  assign rsp_valid     = (state == RESP);
  assign rsp_data      = data_q;
  assign rsp_rd        = rd_q;
  assign rsp_err       = err_q;

endmodule

// File: tb/tb_fpu_zhinx_issue.sv
// Bench for fpu_zhinx_issue: directed cases plus randomized ops,
// with a real-valued half-precision responder and transaction-level expectations.
module tb_fpu_zhinx_issue;
  import fpu_zhinx_pkg::*;

  localparam int W = 32;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic           req_valid = 1'b0;
  logic           req_ready;
  fpu_operation_t req_op = FPU_HALF_ADD;
  logic [W-1:0]   req_a = '0;
  logic [W-1:0]   req_b = '0;
  logic [4:0]     req_rd = '0;
  logic           fpu_start;
  fpu_operation_t fpu_operation;
  logic [W-1:0]   fpu_a;
  logic [W-1:0]   fpu_b;
  logic           fpu_done;
  logic [W-1:0]   fpu_out;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [W-1:0]   rsp_data;
  logic [4:0]     rsp_rd;
  logic           rsp_err;

  int n_chk = 0;
  int n_pass = 0;
  int dly = 0;
  bit tie0 = 1'b0;
  int bcnt = 0;

  fpu_zhinx_issue #(.WORD_W(W), .TIMEOUT_CYCLES(64)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
    .fpu_start(fpu_start), .fpu_operation(fpu_operation),
    .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_done(fpu_done), .fpu_out(fpu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_rd(rsp_rd), .rsp_err(rsp_err)
  );

  always #5 CLK = ~CLK;

  function automatic real h2r(input logic [15:0] h);
    real v;
    int e;
    if (h[14:0] == 15'd0) return 0.0;
    v = 1.0 + real'(h[9:0]) / 1024.0;
    e = int'(h[14:10]) - 15;
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return h[15] ? -v : v;
  endfunction

  function automatic logic [15:0] r2h(input real x);
    logic s;
    real m;
    int e;
    s = (x < 0.0);
    m = s ? -x : x;
    e = 15;
    if (m == 0.0) return 16'h0000;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    return {s, 5'(e), 10'(int'((m - 1.0) * 1024.0))};
  endfunction

  function automatic logic [15:0] half_op(input fpu_operation_t op,
                                          input logic [15:0] a,
                                          input logic [15:0] b);
    case (op)
      FPU_HALF_ADD: return r2h(h2r(a) + h2r(b));
      FPU_HALF_SUB: return r2h(h2r(a) - h2r(b));
      FPU_HALF_MUL: return r2h(h2r(a) * h2r(b));
      default:      return 16'h0000;
    endcase
  endfunction

  // Responder: done after dly BUSY cycles, or never when tie0 is set.
  always @(posedge CLK) bcnt <= fpu_start ? bcnt + 1 : 0;
  assign fpu_done = fpu_start && !tie0 && (bcnt >= dly);
  assign fpu_out  = fpu_done ?
    {16'h0000, half_op(fpu_operation, fpu_a[15:0], fpu_b[15:0])} : '0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  task automatic noise();
    req_valid = 1'($urandom_range(0, 1));
    req_a     = $urandom;
    req_b     = $urandom;
    req_rd    = 5'($urandom);
    req_op    = fpu_operation_t'($urandom_range(0, 7));
  endtask

  // Entered and left on a falling edge.
  task automatic run_op(input fpu_operation_t op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input int d, input int bp);
    bit sup;
    logic [31:0] exp_d;
    int edges;
    sup   = op inside {FPU_HALF_ADD, FPU_HALF_SUB, FPU_HALF_MUL};
    exp_d = sup ? {16'h0000, half_op(op, a[15:0], b[15:0])} : 32'h0;
    dly   = d;
    chk("idle_rdy", req_ready, 1);
    req_valid = 1'b1;
    req_op = op; req_a = a; req_b = b; req_rd = rd;
    @(posedge CLK);
    @(negedge CLK);
    req_valid = 1'b0;
    edges = 1;
    while (!rsp_valid && edges <= 200) begin
      chk("busy_start", fpu_start, 32'(sup));
      chk("busy_rdy", req_ready, 0);
      if (sup) begin
        chk("hold_a", fpu_a, a);
        chk("hold_b", fpu_b, b);
        chk("hold_op", fpu_operation, op);
      end
      noise();
      @(negedge CLK);
      edges++;
    end
    chk("latency", edges, sup ? 2 + d : 1);
    for (int i = 0; i <= bp; i++) begin
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_data", rsp_data, exp_d);
      chk("rsp_rd", rsp_rd, rd);
      chk("rsp_err", rsp_err, 32'(!sup));
      chk("rsp_rdy", req_ready, 0);
      chk("rsp_start", fpu_start, 0);
      if (i < bp) begin
        noise();
        @(negedge CLK);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge CLK);
    rsp_ready = 1'b0;
    chk("post_valid", rsp_valid, 0);
    chk("post_rdy", req_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;
    logic [15:0] hi;
    fpu_operation_t rop;
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    chk("rst_rdy", req_ready, 1);
    chk("rst_start", fpu_start, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_rd", rsp_rd, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_op", fpu_operation, FPU_HALF_ADD);
    chk("rst_a", fpu_a, 0);
    RST = 1'b0;

    run_op(FPU_HALF_ADD, 32'h3C00, 32'h3C00, 5'd5, 0, 0);
    chk("add_lit", rsp_data, 32'h0000_4000);
    run_op(FPU_HALF_MUL, 32'h4000, 32'h4200, 5'd2, 3, 0);
    chk("mul_lit", half_op(FPU_HALF_MUL, 16'h4000, 16'h4200), 32'h4600);
    run_op(FPU_HALF_SUB, 32'h4000, 32'h3C00, 5'd9, 0, 5);
    chk("sub_lit", half_op(FPU_HALF_SUB, 16'h4000, 16'h3C00), 32'h3C00);
    run_op(FPU_HALF_DIV, 32'h4000, 32'h3C00, 5'd7, 0, 1);

    tie0 = 1'b1;
    req_valid = 1'b1;
    req_op = FPU_HALF_ADD; req_a = 32'h3C00; req_b = 32'h3C00; req_rd = 5'd4;
    @(posedge CLK);
    @(negedge CLK);
    req_valid = 1'b0;
    chk("mid_start1", fpu_start, 1);
    @(negedge CLK);
    chk("mid_start2", fpu_start, 1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("mid_start", fpu_start, 0);
    chk("mid_rdy", req_ready, 1);
    chk("mid_valid", rsp_valid, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      chk("mid_norsp", rsp_valid, 0);
    end

    req_valid = 1'b1;
    req_op = FPU_HALF_MUL; req_a = 32'h4000; req_b = 32'h4000; req_rd = 5'd3;
    @(posedge CLK);
    @(negedge CLK);
    req_valid = 1'b0;
    edges = 1;
    while (!rsp_valid && edges <= 1000) begin
      @(negedge CLK);
      edges++;
    end
`ifdef FPU_ZHINX_ISSUE_TIMEOUT_EN
    chk("to_edges", edges, 65);
    chk("to_err", rsp_err, 1);
    chk("to_data", rsp_data, 0);
    chk("to_rd", rsp_rd, 3);
    chk("to_start", fpu_start, 0);
    rsp_ready = 1'b1;
    @(negedge CLK);
    rsp_ready = 1'b0;
`else
    chk("to_edges", edges, 1001);
    chk("to_start", fpu_start, 1);
    chk("to_valid", rsp_valid, 0);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
`endif
    tie0 = 1'b0;
    chk("to_rdy", req_ready, 1);

    for (int n = 0; n < 40; n++) begin
      rop = fpu_operation_t'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        rop = fpu_operation_t'($urandom_range(0, 2));
      end
      hi = 16'($urandom);
      run_op(rop,
             {hi, r2h(real'($urandom_range(1, 8)))},
             {16'h0000, r2h(real'($urandom_range(1, 8)))},
             5'($urandom), $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
